csr_access_unit: RTL and testbench

//  Initiator for the CSR register file (12-bit addr, 1-cycle registered read, write on wen at posedge, trap_vector = mtvec).

---
 rtl/csr_pkg.sv | 35 +++
 rtl/csr_alu.sv | 36 +++
 rtl/csr_access_unit.sv | 211 +++++++++++++++++++++
 tb/tb_csr_access_unit.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// Shared definitions for the CSR access unit.
// Holds the default widths, the fixed machine-mode CSR addresses,
// the request kind/op encodings and the sequencer state encoding.
package csr_pkg;

    localparam int unsigned CSR_WORD_LEN   = 32;
    localparam int unsigned CSR_ADDR_LEN   = 12;
    localparam logic [11:0] CSR_EPC_ADDR   = 12'h341;
    localparam logic [11:0] CSR_CAUSE_ADDR = 12'h342;
    localparam logic [11:0] CSR_MTVEC_ADDR = 12'h305;

    typedef enum logic [1:0] {
        KIND_CSR  = 2'd0,
        KIND_TRAP = 2'd1,
        KIND_MRET = 2'd2,
        KIND_NOP  = 2'd3
    } kind_e;

    typedef enum logic [1:0] {
        OP_RW = 2'd0,
        OP_RS = 2'd1,
        OP_RC = 2'd2,
        OP_RO = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_ADDR = 3'd1,
        S_RD_DATA = 3'd2,
        S_T_EPC   = 3'd3,
        S_T_CAUSE = 3'd4,
        S_RESP    = 3'd5
    } state_e;

endpackage

// File: rtl/csr_alu.sv
// Read-modify-write datapath for CSR instructions.
// Ports:
//   op       - 0 RW, 1 RS, 2 RC, 3 read-only
//   old_val  - current CSR contents
//   src_val  - rs1 value or zero-extended immediate
//   no_write - source was x0 / uimm=0 (only honoured by RS/RC)
//   is_csr   - request is a CSR instruction (TRAP/MRET/NOP never write here)
//   new_val  - value to write back
//   wr_ok    - write-back is required
module csr_alu
    import csr_pkg::*;
#(
    parameter int unsigned WIDTH = CSR_WORD_LEN
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] old_val,
    input  logic [WIDTH-1:0] src_val,
    input  logic             no_write,
    input  logic             is_csr,
    output logic [WIDTH-1:0] new_val,
    output logic             wr_ok
);

    // New CSR value and write qualifier; RW always writes even with x0 source.
    always_comb begin
        new_val = old_val;
        case (op)
            OP_RW:   new_val = src_val;
            OP_RS:   new_val = old_val | src_val;
            OP_RC:   new_val = old_val & ~src_val;
            default: new_val = old_val;
        endcase
        wr_ok = is_csr && (op != OP_RO) && ((op == OP_RW) || !no_write);
    end

endmodule

// File: rtl/csr_access_unit.sv
// Sequencer between the execute stage and the CSR register file.
// Runs CSRRW/CSRRS/CSRRC read-modify-write, trap entry (mepc + mcause
// writes, redirect to mtvec), MRET (mepc read, redirect) and NOP.
// One request in flight; req_ready is high only while idle.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   req_*                    - request handshake and latched payload
//   resp_valid/data/redirect - one-cycle completion pulse and result
//   csr_addr/wen/wdata       - CSR file command (address registered,
//                              write enable/data decoded from state)
//   csr_rdata                - CSR file read data, one cycle after address
//   csr_trap_vector          - CSR file mtvec output
module csr_access_unit
    import csr_pkg::*;
#(
    parameter int unsigned WORD_LEN      = CSR_WORD_LEN,
    parameter int unsigned REG_ADDR_SIZE = CSR_ADDR_LEN,
    parameter logic [REG_ADDR_SIZE-1:0] EPC_ADDR   = CSR_EPC_ADDR,
    parameter logic [REG_ADDR_SIZE-1:0] CAUSE_ADDR = CSR_CAUSE_ADDR
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [1:0]               req_kind,
    input  logic [1:0]               req_op,
    input  logic [REG_ADDR_SIZE-1:0] req_addr,
    input  logic [WORD_LEN-1:0]      req_src,
    input  logic                     req_no_write,
    input  logic [WORD_LEN-1:0]      req_pc,
    input  logic [WORD_LEN-1:0]      req_cause,
    output logic                     resp_valid,
    output logic [WORD_LEN-1:0]      resp_data,
    output logic                     resp_redirect,
    output logic [REG_ADDR_SIZE-1:0] csr_addr,
    output logic                     csr_wen,
    output logic [WORD_LEN-1:0]      csr_wdata,
    input  logic [WORD_LEN-1:0]      csr_rdata,
    input  logic [WORD_LEN-1:0]      csr_trap_vector
);

    state_e                   state_q, state_d;
    kind_e                    kind_q, kind_d;
    logic [1:0]               op_q, op_d;
    logic [WORD_LEN-1:0]      src_q, src_d;
    logic [WORD_LEN-1:0]      pc_q, pc_d;
    logic [WORD_LEN-1:0]      cause_q, cause_d;
    logic                     no_write_q, no_write_d;
    logic                     ready_q, ready_d;
    logic                     resp_valid_q, resp_valid_d;
    logic                     resp_redirect_q, resp_redirect_d;
    logic [WORD_LEN-1:0]      resp_data_q, resp_data_d;
    logic [REG_ADDR_SIZE-1:0] csr_addr_q, csr_addr_d;

    logic [WORD_LEN-1:0]      alu_new_s;
    logic                     alu_wr_ok_s;
    logic                     wen_s;
    logic [WORD_LEN-1:0]      wdata_s;

    csr_alu #(
        .WIDTH (WORD_LEN)
    ) u_alu (
        .op       (op_q),
        .old_val  (csr_rdata),
        .src_val  (src_q),
        .no_write (no_write_q),
        .is_csr   (kind_q == KIND_CSR),
        .new_val  (alu_new_s),
        .wr_ok    (alu_wr_ok_s)
    );

    // Next-state and next-output decode for the sequencer.
    always_comb begin
        state_d         = state_q;
        kind_d          = kind_q;
        op_d            = op_q;
        src_d           = src_q;
        pc_d            = pc_q;
        cause_d         = cause_q;
        no_write_d      = no_write_q;
        resp_valid_d    = 1'b0;
        resp_redirect_d = resp_redirect_q;
        resp_data_d     = resp_data_q;
        csr_addr_d      = csr_addr_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    kind_d     = kind_e'(req_kind);
                    op_d       = req_op;
                    src_d      = req_src;
                    pc_d       = req_pc;
                    cause_d    = req_cause;
                    no_write_d = req_no_write;
                    case (kind_e'(req_kind))
                        KIND_CSR: begin
                            csr_addr_d = req_addr;
                            state_d    = S_RD_ADDR;
                        end
                        KIND_MRET: begin
                            csr_addr_d = EPC_ADDR;
                            state_d    = S_RD_ADDR;
                        end
                        KIND_TRAP: begin
                            csr_addr_d = EPC_ADDR;
                            state_d    = S_T_EPC;
                        end
                        default: begin
                            resp_data_d     = {WORD_LEN{1'b0}};
                            resp_redirect_d = 1'b0;
                            resp_valid_d    = 1'b1;
                            state_d         = S_RESP;
                        end
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD_ADDR: state_d = S_RD_DATA;
            S_RD_DATA: begin
                resp_data_d     = csr_rdata;
                resp_redirect_d = (kind_q == KIND_MRET);
                resp_valid_d    = 1'b1;
                state_d         = S_RESP;
            end
            S_T_EPC: begin
                csr_addr_d = CAUSE_ADDR;
                state_d    = S_T_CAUSE;
            end
            S_T_CAUSE: begin
                // mtvec is never a trap-entry write target, so this sample is current.
                resp_data_d     = csr_trap_vector;
                resp_redirect_d = 1'b1;
                resp_valid_d    = 1'b1;
                state_d         = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        ready_d = (state_d == S_IDLE);
    end

    // CSR file write command; forced off while reset is asserted so an aborted sequence never writes.
    always_comb begin
        wen_s   = 1'b0;
        wdata_s = {WORD_LEN{1'b0}};
        case (state_q)
            S_RD_DATA: begin
                wen_s   = alu_wr_ok_s;
                wdata_s = alu_new_s;
            end
            S_T_EPC: begin
                wen_s   = 1'b1;
                wdata_s = pc_q;
            end
            S_T_CAUSE: begin
                wen_s   = 1'b1;
                wdata_s = cause_q;
            end
            default: begin
                wen_s   = 1'b0;
                wdata_s = {WORD_LEN{1'b0}};
            end
        endcase
        if (rst) begin
            wen_s   = 1'b0;
            wdata_s = {WORD_LEN{1'b0}};
        end else begin
            wen_s   = wen_s;
        end
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            kind_q          <= KIND_NOP;
            op_q            <= 2'd0;
            src_q           <= {WORD_LEN{1'b0}};
            pc_q            <= {WORD_LEN{1'b0}};
            cause_q         <= {WORD_LEN{1'b0}};
            no_write_q      <= 1'b0;
            ready_q         <= 1'b1;
            resp_valid_q    <= 1'b0;
            resp_redirect_q <= 1'b0;
            resp_data_q     <= {WORD_LEN{1'b0}};
            csr_addr_q      <= {REG_ADDR_SIZE{1'b0}};
        end else begin
            state_q         <= state_d;
            kind_q          <= kind_d;
            op_q            <= op_d;
            src_q           <= src_d;
            pc_q            <= pc_d;
            cause_q         <= cause_d;
            no_write_q      <= no_write_d;
            ready_q         <= ready_d;
            resp_valid_q    <= resp_valid_d;
            resp_redirect_q <= resp_redirect_d;
            resp_data_q     <= resp_data_d;
            csr_addr_q      <= csr_addr_d;
        end
    end

    assign req_ready     = ready_q;
    assign resp_valid    = resp_valid_q;
    assign resp_data     = resp_data_q;
    assign resp_redirect = resp_redirect_q;
    assign csr_addr      = csr_addr_q;
    assign csr_wen       = wen_s;
    assign csr_wdata     = wdata_s;

endmodule

// File: tb/tb_csr_access_unit.sv
// Directed testbench for csr_access_unit with a small CSR register file model
// (registered read, write at posedge, mtvec at 0x305).
module tb_csr_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_kind;
    logic [1:0]  req_op;
    logic [11:0] req_addr;
    logic [31:0] req_src;
    logic        req_no_write;
    logic [31:0] req_pc;
    logic [31:0] req_cause;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_redirect;
    logic [11:0] csr_addr;
    logic        csr_wen;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic [31:0] csr_trap_vector;

    logic        bd_we;
    logic [11:0] bd_addr;
    logic [31:0] bd_data;
    logic [31:0] mem [0:4095];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    csr_access_unit dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_kind        (req_kind),
        .req_op          (req_op),
        .req_addr        (req_addr),
        .req_src         (req_src),
        .req_no_write    (req_no_write),
        .req_pc          (req_pc),
        .req_cause       (req_cause),
        .resp_valid      (resp_valid),
        .resp_data       (resp_data),
        .resp_redirect   (resp_redirect),
        .csr_addr        (csr_addr),
        .csr_wen         (csr_wen),
        .csr_wdata       (csr_wdata),
        .csr_rdata       (csr_rdata),
        .csr_trap_vector (csr_trap_vector)
    );

    // CSR register file model: backdoor preload, write on wen, registered read.
    always @(posedge clk) begin
        csr_rdata <= mem[csr_addr];
        if (bd_we) mem[bd_addr] <= bd_data;
        else if (csr_wen) mem[csr_addr] <= csr_wdata;
    end
    assign csr_trap_vector = mem[12'h305];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        @(posedge clk);
        #1 bd_we = 1'b0;
    endtask

    // Issue one request from a negedge, then follow it cycle by cycle up to the response.
    task automatic do_req(input logic [1:0] kind, input logic [1:0] op, input logic [11:0] addr,
                          input logic [31:0] src, input logic nw, input logic [31:0] pc,
                          input logic [31:0] cause, output int lat, output logic [31:0] data,
                          output logic redir, output int nwr, output logic [11:0] wa0,
                          output logic [11:0] wa1, output logic [31:0] wd0, output logic [31:0] wd1);
        int wait_cnt = 0;
        lat = 0; nwr = 0; data = 'x; redir = 1'bx;
        wa0 = 'x; wa1 = 'x; wd0 = 'x; wd1 = 'x;
        @(negedge clk);
        while (req_ready !== 1'b1 && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        check("ready_before_req", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_kind = kind; req_op = op; req_addr = addr;
        req_src = src; req_no_write = nw; req_pc = pc; req_cause = cause;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (csr_wen === 1'b1) begin
                if (nwr == 0) begin wa0 = csr_addr; wd0 = csr_wdata; end
                else begin wa1 = csr_addr; wd1 = csr_wdata; end
                nwr++;
            end
            if (resp_valid === 1'b1) begin
                lat = c; data = resp_data; redir = resp_redirect;
                check("ready_low_in_resp", {31'd0, req_ready}, 32'd0);
                break;
            end
        end
    endtask

    int          lat;
    int          nwr;
    logic [31:0] data;
    logic        redir;
    logic [11:0] wa0, wa1;
    logic [31:0] wd0, wd1;

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_kind = 2'd3; req_op = 2'd0; req_addr = 12'h000;
        req_src = 32'h0; req_no_write = 1'b0; req_pc = 32'h0; req_cause = 32'h0;
        bd_we = 1'b0; bd_addr = 12'h000; bd_data = 32'h0;

        preload(12'h300, 32'h0000_1888);
        preload(12'h304, 32'h0000_00F0);
        preload(12'h305, 32'h8000_0100);
        preload(12'h340, 32'h0000_0000);
        preload(12'h341, 32'h1111_1111);
        preload(12'h342, 32'h2222_2222);

        // Reset state
        @(negedge clk);
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_redirect", {31'd0, resp_redirect}, 32'd0);
        check("rst_resp_data", resp_data, 32'h0);
        check("rst_csr_addr", {20'd0, csr_addr}, 32'h0);
        check("rst_wen", {31'd0, csr_wen}, 32'd0);
        check("rst_wdata", csr_wdata, 32'h0);
        rst = 1'b0;

        // Reset in the middle of a TRAP sequence
        @(negedge clk);
        req_valid = 1'b1; req_kind = 2'd1; req_pc = 32'h1234_5678; req_cause = 32'h5;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("trap_epc_wen_before_rst", {31'd0, csr_wen}, 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_wen_now", {31'd0, csr_wen}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("midrst_wen", {31'd0, csr_wen}, 32'd0);
            check("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("postrst_ready", {31'd0, req_ready}, 32'd1);
            check("postrst_resp_valid", {31'd0, resp_valid}, 32'd0);
        end
        check("midrst_mepc_untouched", mem[12'h341], 32'h1111_1111);
        check("midrst_mcause_untouched", mem[12'h342], 32'h2222_2222);

        // CSRRW 0x300
        do_req(2'd0, 2'd0, 12'h300, 32'hDEAD_BEEF, 1'b0, 32'h0, 32'h0,
               lat, data, redir, nwr, wa0, wa1, wd0, wd1);
        check("rw_lat", lat, 32'd3);
        check("rw_nwr", nwr, 32'd1);
        check("rw_waddr", {20'd0, wa0}, 32'h300);
        check("rw_wdata", wd0, 32'hDEAD_BEEF);
        check("rw_data", data, 32'h0000_1888);
        check("rw_redir", {31'd0, redir}, 32'd0);

        // CSRRS 0x304 src 0x0F, old 0xF0
        do_req(2'd0, 2'd1, 12'h304, 32'h0000_000F, 1'b0, 32'h0, 32'h0,
               lat, data, redir, nwr, wa0, wa1, wd0, wd1);
        check("rs_nwr", nwr, 32'd1);
        check("rs_wdata", wd0, 32'h0000_00FF);
        check("rs_data", data, 32'h0000_00F0);

        // CSRRC 0x304 src 0x30, old 0xFF
        do_req(2'd0, 2'd2, 12'h304, 32'h0000_0030, 1'b0, 32'h0, 32'h0,
               lat, data, redir, nwr, wa0, wa1, wd0, wd1);
        check("rc_nwr", nwr, 32'd1);
        check("rc_wdata", wd0, 32'h0000_00CF);
        check("rc_data", data, 32'h0000_00FF);

        // CSRRS with no_write: read only
        do_req(2'd0, 2'd1, 12'h304, 32'h0000_0000, 1'b1, 32'h0, 32'h0,
               lat, data, redir, nwr, wa0, wa1, wd0, wd1);
        check("rs_nw_nwr", nwr, 32'd0);
        check("rs_nw_data", data, 32'h0000_00CF);

        // Read-only op never writes
        do_req(2'd0, 2'd3, 12'h300, 32'h0000_1234, 1'b0, 32'h0, 32'h0,
               lat, data, redir, nwr, wa0, wa1, wd0, wd1);
        check("ro_nwr", nwr, 32'd0);
        check("ro_data", data, 32'hDEAD_BEEF);

        // CSRRW 0x340 = 5 with no_write set: RW still writes
        do_req(2'd0, 2'd0, 12'h340, 32'h0000_0005, 1'b1, 32'h0, 32'h0,
               lat, data, redir, nwr, wa0, wa1, wd0, wd1);
        check("rw_nw_nwr", nwr, 32'd1);
        check("rw_nw_wdata", wd0, 32'h0000_0005);

        // Back-to-back read of the same address sees the new value
        do_req(2'd0, 2'd1, 12'h340, 32'h0000_0000, 1'b1, 32'h0, 32'h0,
               lat, data, redir, nwr, wa0, wa1, wd0, wd1);
        check("raw_data", data, 32'h0000_0005);
        check("raw_nwr", nwr, 32'd0);

        // TRAP
        do_req(2'd1, 2'd0, 12'h000, 32'h0, 1'b0, 32'h8000_0040, 32'h0000_000B,
               lat, data, redir, nwr, wa0, wa1, wd0, wd1);
        check("trap_lat", lat, 32'd3);
        check("trap_nwr", nwr, 32'd2);
        check("trap_waddr0", {20'd0, wa0}, 32'h341);
        check("trap_wdata0", wd0, 32'h8000_0040);
        check("trap_waddr1", {20'd0, wa1}, 32'h342);
        check("trap_wdata1", wd1, 32'h0000_000B);
        check("trap_data", data, 32'h8000_0100);
        check("trap_redir", {31'd0, redir}, 32'd1);

        // MRET
        do_req(2'd2, 2'd0, 12'h000, 32'h0, 1'b0, 32'h0, 32'h0,
               lat, data, redir, nwr, wa0, wa1, wd0, wd1);
        check("mret_lat", lat, 32'd3);
        check("mret_nwr", nwr, 32'd0);
        check("mret_data", data, 32'h8000_0040);
        check("mret_redir", {31'd0, redir}, 32'd1);

        // NOP
        do_req(2'd3, 2'd0, 12'h300, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h0,
               lat, data, redir, nwr, wa0, wa1, wd0, wd1);
        check("nop_lat", lat, 32'd1);
        check("nop_nwr", nwr, 32'd0);
        check("nop_data", data, 32'h0);
        check("nop_redir", {31'd0, redir}, 32'd0);

        @(negedge clk);
        check("final_resp_valid_drops", {31'd0, resp_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
